// File: rtl/display_pkg.sv
// Shared segment constants for the seven-segment display path.
// Glyphs are active-high, bit order {a,b,c,d,e,f,g}.
package display_pkg;

    typedef logic [6:0] glyph_t;

    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam glyph_t GLYPH_0 = 7'b1111110;
    localparam glyph_t GLYPH_1 = 7'b0110000;
    localparam glyph_t GLYPH_2 = 7'b1101101;
    localparam glyph_t GLYPH_3 = 7'b1111001;
    localparam glyph_t GLYPH_4 = 7'b0110011;
    localparam glyph_t GLYPH_5 = 7'b1011011;
    localparam glyph_t GLYPH_6 = 7'b1011111;
    localparam glyph_t GLYPH_7 = 7'b1110000;
    localparam glyph_t GLYPH_8 = 7'b1111111;
    localparam glyph_t GLYPH_9 = 7'b1111011;
    localparam glyph_t GLYPH_A = 7'b1110111;
    localparam glyph_t GLYPH_B = 7'b0011111;
    localparam glyph_t GLYPH_C = 7'b1001110;
    localparam glyph_t GLYPH_D = 7'b0111101;
    localparam glyph_t GLYPH_E = 7'b1001111;
    localparam glyph_t GLYPH_F = 7'b1000111;

    localparam glyph_t GLYPH_OFF = '0;
    localparam glyph_t GLYPH_ALL = '1;

    // Source chosen for the next segment pattern.
    typedef enum logic [1:0] {
        SRC_OFF,
        SRC_ALL,
        SRC_DIGIT
    } src_t;

endpackage

// File: rtl/seg7_lut.sv
// Combinational 4-bit digit to active-high seven-segment glyph lookup.
module seg7_lut
    import display_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] digit,
    output glyph_t     glyph
);

    always_comb begin
        glyph = GLYPH_OFF;
        case (digit)
            4'd0:  glyph = GLYPH_0;
            4'd1:  glyph = GLYPH_1;
            4'd2:  glyph = GLYPH_2;
            4'd3:  glyph = GLYPH_3;
            4'd4:  glyph = GLYPH_4;
            4'd5:  glyph = GLYPH_5;
            4'd6:  glyph = GLYPH_6;
            4'd7:  glyph = GLYPH_7;
            4'd8:  glyph = GLYPH_8;
            4'd9:  glyph = GLYPH_9;
            // Non-decimal codes stay dark unless hex display is enabled.
            4'd10: glyph = HEX_EN ? GLYPH_A : GLYPH_OFF;
            4'd11: glyph = HEX_EN ? GLYPH_B : GLYPH_OFF;
            4'd12: glyph = HEX_EN ? GLYPH_C : GLYPH_OFF;
            4'd13: glyph = HEX_EN ? GLYPH_D : GLYPH_OFF;
            4'd14: glyph = HEX_EN ? GLYPH_E : GLYPH_OFF;
            4'd15: glyph = HEX_EN ? GLYPH_F : GLYPH_OFF;
            default: glyph = GLYPH_OFF;
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// BCD/hex to seven-segment decoder with lamp-test, blanking and a
// registered, polarity-selectable segment output.
module display_decoder
    import display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_EN     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_in,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] led
);

    glyph_t glyph;
    glyph_t lit;
    glyph_t drive;
    glyph_t off_drive;
    src_t   src;

    seg7_lut #(
        .HEX_EN (HEX_EN)
    ) u_lut (
        .digit (led_in),
        .glyph (glyph)
    );

    always_comb begin
        src = SRC_DIGIT;
        if (lamp_test)
            src = SRC_ALL;
        else if (blank)
            src = SRC_OFF;
    end

    always_comb begin
        lit = GLYPH_OFF;
        case (src)
            SRC_ALL:   lit = GLYPH_ALL;
            SRC_OFF:   lit = GLYPH_OFF;
            SRC_DIGIT: lit = glyph;
            default:   lit = GLYPH_OFF;
        endcase
    end

    // Common-anode pins sink current, so lit segments drive low.
    assign drive     = ACTIVE_LOW ? ~lit : lit;
    assign off_drive = ACTIVE_LOW ? ~GLYPH_OFF : GLYPH_OFF;

    always_ff @(posedge clk) begin
        if (rst)
            led <= off_drive;
        else
            led <= drive;
    end

endmodule

// File: tb/tb_display_decoder.sv
// Bench for display_decoder: three parameter variants share one stimulus
// stream and are compared against a table-driven reference model.
module tb_display_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] led_in = 4'd0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [6:0] led_dec;
    logic [6:0] led_hex;
    logic [6:0] led_pos;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    display_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) dut_dec (
        .clk(clk), .rst(rst), .led_in(led_in), .blank(blank),
        .lamp_test(lamp_test), .led(led_dec));

    display_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_hex (
        .clk(clk), .rst(rst), .led_in(led_in), .blank(blank),
        .lamp_test(lamp_test), .led(led_hex));

    display_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_pos (
        .clk(clk), .rst(rst), .led_in(led_in), .blank(blank),
        .lamp_test(lamp_test), .led(led_pos));

    // Common-anode patterns (abcdefg, 0 = lit) for 0-9 then A-F.
    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100,
        7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010,
        7'b0110000, 7'b0111000};

    function automatic logic [6:0] model(input bit active_low, input bit hex,
                                         input logic r, input logic lt,
                                         input logic bl, input logic [3:0] d);
        logic [6:0] p;
        if (r)                p = 7'b1111111;
        else if (lt)          p = 7'b0000000;
        else if (bl)          p = 7'b1111111;
        else if (d < 4'd10)   p = tbl[d];
        else if (hex)         p = tbl[d];
        else                  p = 7'b1111111;
        return active_low ? p : ~p;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic lt, input logic bl,
                        input logic [3:0] d, input string tag);
        logic [6:0] e_dec, e_hex, e_pos;
        @(negedge clk);
        rst = r; lamp_test = lt; blank = bl; led_in = d;
        e_dec = model(1'b1, 1'b0, r, lt, bl, d);
        e_hex = model(1'b1, 1'b1, r, lt, bl, d);
        e_pos = model(1'b0, 1'b0, r, lt, bl, d);
        @(posedge clk);
        #1;
        check({tag, "_dec"}, led_dec, e_dec);
        check({tag, "_hex"}, led_hex, e_hex);
        check({tag, "_pos"}, led_pos, e_pos);
    endtask

    initial begin
        // Reset with led_in=8 held for two cycles, then release.
        step(1'b1, 1'b0, 1'b0, 4'd8, "reset0");
        step(1'b1, 1'b0, 1'b0, 4'd8, "reset1");
        check("reset_dec_const", led_dec, 7'b1111111);
        check("reset_pos_const", led_pos, 7'b0000000);
        step(1'b0, 1'b0, 1'b0, 4'd8, "release");
        check("release_dec_const", led_dec, 7'b0000000);

        // Digit sweep with a one-cycle reset pulse in the middle.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'(i), "sweep");
            if (i == 4) begin
                check("sweep4_const", led_dec, 7'b1001100);
                step(1'b1, 1'b0, 1'b0, 4'd5, "midrst");
                check("midrst_const", led_dec, 7'b1111111);
            end
        end
        check("sweep9_const", led_dec, 7'b0000100);

        // Non-decimal codes, both hex settings.
        step(1'b0, 1'b0, 1'b0, 4'd10, "inv10");
        check("inv10_hex_const", led_hex, 7'b0001000);
        step(1'b0, 1'b0, 1'b0, 4'd15, "inv15");
        check("inv15_hex_const", led_hex, 7'b0111000);
        check("inv15_dec_const", led_dec, 7'b1111111);
        for (int i = 10; i < 16; i++)
            step(1'b0, 1'b0, 1'b0, 4'(i), "hexsweep");

        // Blank, lamp-test priority, release.
        step(1'b0, 1'b0, 1'b1, 4'd3, "blank");
        check("blank_const", led_dec, 7'b1111111);
        step(1'b0, 1'b1, 1'b1, 4'd3, "lt_blank");
        check("lt_blank_const", led_dec, 7'b0000000);
        step(1'b0, 1'b0, 1'b0, 4'd3, "release3");
        check("release3_const", led_dec, 7'b0000110);

        // Polarity check on the non-inverted variant.
        step(1'b0, 1'b0, 1'b0, 4'd1, "pol1");
        check("pol1_const", led_pos, 7'b0110000);

        // Reset beats lamp test.
        step(1'b1, 1'b1, 1'b0, 4'd8, "rst_lt");

        // Randomised stream against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(5) == 0), 4'($urandom_range(15)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
